mem_access_sequencer: RTL and testbench

Multicycle sequencer that time-shares one single-port memory between instruction fetch and load/store for the `Data_Flow` datapath. Per instruction it:
- fetches the word at `PC` and presents it on `Inst`;
- performs any data read or write the datapath requests, returning load data on `Data`;
- pulses `Step` so the datapath commits its PC and register writes.

It sits between `Data_Flow` and the memory model, replacing the hand-driven `Inst`/`Data` stimulus.

---
 rtl/mem_access_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// Multicycle sequencer sharing one single-port memory between instruction fetch and load/store.
// Optional feature: define MEM_TIMEOUT_EN to fault (code 11) when MemAck does not arrive within TIMEOUT cycles.
module mem_access_sequencer #(
    parameter logic [15:0] TIMEOUT = 16'd255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Run,
    input  logic [31:0] PC,
    input  logic        DpMemRead,
    input  logic        DpMemWrite,
    input  logic [31:0] DpAddr,
    input  logic [31:0] DpWData,
    output logic [31:0] Inst,
    output logic [31:0] Data,
    output logic        Step,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck,
    output logic        Busy,
    output logic        Fault,
    output logic [1:0]  FaultCode,
    output logic [31:0] InstCount
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_MISALIGN  = 2'b01;
    localparam logic [1:0] FC_CONFLICT  = 2'b10;
    localparam logic [1:0] FC_TIMEOUT   = 2'b11;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [1:0]  fault_code;
    logic [1:0]  fault_code_nxt;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_we;
    logic [31:0] inst_count;
    logic        fetch_req;
    logic        data_req;
    logic        mem_req;
    logic        wait_expired;

    // A misaligned PC never reaches the memory: the request is suppressed in the same cycle.
    assign fetch_req = (state == S_FETCH) && (PC[1:0] == 2'b00);
    assign data_req  = (state == S_DATA);
    assign mem_req   = fetch_req || data_req;

`ifdef MEM_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_inc;

    assign wait_cnt_inc = wait_cnt + 16'd1;
    assign wait_expired = (wait_cnt_inc >= TIMEOUT);

    always_ff @(posedge Clock) begin
        if (Reset || !mem_req || MemAck) begin
            wait_cnt <= 16'd0;
        end else begin
            wait_cnt <= wait_cnt_inc;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign wait_expired   = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        fault_code_nxt = fault_code;
        case (state)
            S_IDLE: begin
                if (Run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (PC[1:0] != 2'b00) begin
                    state_nxt      = S_FAULT;
                    fault_code_nxt = FC_MISALIGN;
                end else if (MemAck) begin
                    state_nxt = S_DECODE;
                end else if (wait_expired) begin
                    state_nxt      = S_FAULT;
                    fault_code_nxt = FC_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (DpMemRead && DpMemWrite) begin
                    state_nxt      = S_FAULT;
                    fault_code_nxt = FC_CONFLICT;
                end else if ((DpMemRead || DpMemWrite) && (DpAddr[1:0] != 2'b00)) begin
                    state_nxt      = S_FAULT;
                    fault_code_nxt = FC_MISALIGN;
                end else if (DpMemRead || DpMemWrite) begin
                    state_nxt = S_DATA;
                end else begin
                    state_nxt = S_COMMIT;
                end
            end
            S_DATA: begin
                if (MemAck) begin
                    state_nxt = S_COMMIT;
                end else if (wait_expired) begin
                    state_nxt      = S_FAULT;
                    fault_code_nxt = FC_TIMEOUT;
                end
            end
            S_COMMIT: begin
                state_nxt = Run ? S_FETCH : S_IDLE;
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt      = S_IDLE;
                fault_code_nxt = FC_NONE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            fault_code <= FC_NONE;
            Inst       <= 32'd0;
            Data       <= 32'd0;
            data_addr  <= 32'd0;
            data_wdata <= 32'd0;
            data_we    <= 1'b0;
            inst_count <= 32'd0;
        end else begin
            state      <= state_nxt;
            fault_code <= fault_code_nxt;
            if (fetch_req && MemAck) Inst <= MemRData;
            if (state == S_DECODE) begin
                data_addr  <= DpAddr;
                data_wdata <= DpWData;
                data_we    <= DpMemWrite;
            end
            if (data_req && MemAck && !data_we) Data <= MemRData;
            if (state == S_COMMIT) inst_count <= inst_count + 32'd1;
        end
    end

    assign MemReq    = mem_req;
    assign MemWe     = data_req && data_we;
    assign MemAddr   = fetch_req ? PC : (data_req ? data_addr : 32'd0);
    assign MemWData  = (data_req && data_we) ? data_wdata : 32'd0;
    assign Step      = (state == S_COMMIT);
    assign Busy      = (state != S_IDLE) && (state != S_FAULT);
    assign Fault     = (state == S_FAULT);
    assign FaultCode = fault_code;
    assign InstCount = inst_count;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a wait-state-configurable memory responder.
// Build with MEM_TIMEOUT_EN defined to exercise the timeout fault path.
module tb_mem_access_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Run;
    logic [31:0] PC;
    logic        DpMemRead;
    logic        DpMemWrite;
    logic [31:0] DpAddr;
    logic [31:0] DpWData;
    logic [31:0] Inst;
    logic [31:0] Data;
    logic        Step;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;
    logic        Busy;
    logic        Fault;
    logic [1:0]  FaultCode;
    logic [31:0] InstCount;

    logic [31:0] mem [0:255];
    logic        ack_en;
    int          fetch_waits;
    int          data_waits;
    int          wait_cnt;
    int          cur_waits;
    int          cycle;
    int          wr_cycles;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    int          commit_req_viol;
    int          total;
    int          bad;

    mem_access_sequencer #(.TIMEOUT(16'd4)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .PC(PC),
        .DpMemRead(DpMemRead), .DpMemWrite(DpMemWrite), .DpAddr(DpAddr), .DpWData(DpWData),
        .Inst(Inst), .Data(Data), .Step(Step),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData), .MemAck(MemAck),
        .Busy(Busy), .Fault(Fault), .FaultCode(FaultCode), .InstCount(InstCount)
    );

    always #5 Clock = ~Clock;

    initial begin
        cycle = 0;
        forever begin
            @(posedge Clock);
            cycle = cycle + 1;
        end
    end

    // Memory responder: acks after the configured number of wait cycles, and records write/commit activity.
    initial begin
        MemAck = 1'b0; MemRData = 32'h0; wait_cnt = 0;
        wr_cycles = 0; wr_addr = 32'h0; wr_data = 32'h0; commit_req_viol = 0;
        forever begin
            @(negedge Clock);
            if (MemReq && MemWe) begin
                wr_cycles = wr_cycles + 1; wr_addr = MemAddr; wr_data = MemWData;
            end
            if (Step && MemReq) commit_req_viol = commit_req_viol + 1;
            if (MemAck) begin
                MemAck = 1'b0; MemRData = 32'hA5A5A5A5; wait_cnt = 0;
            end else if (MemReq && ack_en) begin
                cur_waits = (MemAddr == PC && !MemWe) ? fetch_waits : data_waits;
                if (wait_cnt >= cur_waits) begin
                    MemAck = 1'b1; MemRData = mem[MemAddr[9:2]];
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired got=time_limit exp=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic start_instr(output int c0);
        Run = 1'b1;
        @(posedge Clock); #1;
        c0 = cycle;
        Run = 1'b0;
    endtask

    task automatic wait_step(input int c0, input int limit, output int delta);
        delta = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge Clock);
            if (Step) begin
                delta = cycle - c0;
                break;
            end
        end
    endtask

    task automatic pulse_reset;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        int c0, delta;
        Reset = 1'b1; Run = 1'b0; PC = 32'h0;
        DpMemRead = 1'b0; DpMemWrite = 1'b0; DpAddr = 32'h0; DpWData = 32'h0;
        ack_en = 1'b1; fetch_waits = 0; data_waits = 0;
        mem[0] = 32'h00002820;
        repeat (2) @(posedge Clock); #1;
        total++;
        if ({Inst, Data, Step, MemReq, MemWe, MemAddr, MemWData, Busy, Fault, FaultCode, InstCount} !== '0) begin
            bad++; $display("[TB] FAIL reset_outputs got Inst=%h Data=%h MemReq=%b Busy=%b Fault=%b InstCount=%0d exp all zero", Inst, Data, MemReq, Busy, Fault, InstCount);
        end
        Reset = 1'b0;
        start_instr(c0);
        total++;
        if ({MemReq, MemWe, MemAddr, Busy} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
            bad++; $display("[TB] FAIL fetch_request got req=%b we=%b addr=%h busy=%b exp 1 0 0 1", MemReq, MemWe, MemAddr, Busy);
        end
        @(posedge Clock); #1;
        total++;
        if (Inst !== 32'h00002820) begin
            bad++; $display("[TB] FAIL first_inst got=%h exp=%h", Inst, 32'h00002820);
        end
        wait_step(c0, 10, delta);
        total++;
        if (delta !== 2) begin
            bad++; $display("[TB] FAIL nonmem_step_latency got=%0d exp=2", delta);
        end
        @(posedge Clock); #1;
        total++;
        if ({InstCount, Step, Busy} !== {32'd1, 1'b0, 1'b0}) begin
            bad++; $display("[TB] FAIL first_commit got count=%0d step=%b busy=%b exp 1 0 0", InstCount, Step, Busy);
        end
    endtask

    task automatic test_load;
        int c0, delta;
        mem[0] = 32'h8CB10000; mem[4] = 32'h12345678;
        DpMemRead = 1'b1; DpAddr = 32'h10;
        fetch_waits = 1; data_waits = 3;
        start_instr(c0);
        wait_step(c0, 20, delta);
        total++;
        if (delta !== 7) begin
            bad++; $display("[TB] FAIL load_step_latency got=%0d exp=7", delta);
        end
        total++;
        if ({Inst, Data} !== {32'h8CB10000, 32'h12345678}) begin
            bad++; $display("[TB] FAIL load_data got inst=%h data=%h exp 8cb10000 12345678", Inst, Data);
        end
        @(posedge Clock); #1;
        total++;
        if (InstCount !== 32'd2) begin
            bad++; $display("[TB] FAIL load_count got=%0d exp=2", InstCount);
        end
        DpMemRead = 1'b0;
    endtask

    task automatic test_store;
        int c0, delta;
        mem[0] = 32'hAC120020;
        DpMemWrite = 1'b1; DpAddr = 32'h20; DpWData = 32'hDEADBEEF;
        fetch_waits = 0; data_waits = 0; wr_cycles = 0;
        start_instr(c0);
        wait_step(c0, 10, delta);
        total++;
        if (delta !== 3) begin
            bad++; $display("[TB] FAIL store_step_latency got=%0d exp=3", delta);
        end
        total++;
        if ({wr_cycles, wr_addr, wr_data} !== {32'd1, 32'h20, 32'hDEADBEEF}) begin
            bad++; $display("[TB] FAIL store_write got cycles=%0d addr=%h data=%h exp 1 00000020 deadbeef", wr_cycles, wr_addr, wr_data);
        end
        total++;
        if (Data !== 32'h12345678) begin
            bad++; $display("[TB] FAIL store_data_hold got=%h exp=12345678", Data);
        end
        @(posedge Clock); #1;
        DpMemWrite = 1'b0; DpWData = 32'h0;
    endtask

    task automatic test_run_drop;
        int c0, delta;
        mem[0] = 32'h8CB10000; mem[4] = 32'hCAFEF00D;
        DpMemRead = 1'b1; DpAddr = 32'h10;
        fetch_waits = 0; data_waits = 2;
        Run = 1'b1;
        @(posedge Clock); #1;
        c0 = cycle;
        repeat (2) @(posedge Clock); #1;
        total++;
        if ({MemReq, MemWe, MemAddr} !== {1'b1, 1'b0, 32'h10}) begin
            bad++; $display("[TB] FAIL data_request got req=%b we=%b addr=%h exp 1 0 00000010", MemReq, MemWe, MemAddr);
        end
        Run = 1'b0;
        wait_step(c0, 20, delta);
        total++;
        if ({delta, Data} !== {32'd5, 32'hCAFEF00D}) begin
            bad++; $display("[TB] FAIL run_drop_step got delta=%0d data=%h exp 5 cafef00d", delta, Data);
        end
        repeat (4) @(posedge Clock); #1;
        total++;
        if ({Busy, MemReq, InstCount} !== {1'b0, 1'b0, 32'd4}) begin
            bad++; $display("[TB] FAIL run_drop_idle got busy=%b req=%b count=%0d exp 0 0 4", Busy, MemReq, InstCount);
        end
        total++;
        if (commit_req_viol !== 0) begin
            bad++; $display("[TB] FAIL commit_memreq got=%0d exp=0", commit_req_viol);
        end
        DpMemRead = 1'b0;
    endtask

    task automatic test_misaligned_fetch;
        int c0;
        PC = 32'h2;
        start_instr(c0);
        total++;
        if (MemReq !== 1'b0) begin
            bad++; $display("[TB] FAIL misaligned_fetch_req got=%b exp=0", MemReq);
        end
        @(posedge Clock); #1;
        total++;
        if ({Fault, FaultCode, Busy} !== {1'b1, 2'b01, 1'b0}) begin
            bad++; $display("[TB] FAIL misaligned_fetch_fault got fault=%b code=%b busy=%b exp 1 01 0", Fault, FaultCode, Busy);
        end
        Run = 1'b1;
        repeat (3) @(posedge Clock); #1;
        Run = 1'b0;
        total++;
        if ({Fault, FaultCode, MemReq} !== {1'b1, 2'b01, 1'b0}) begin
            bad++; $display("[TB] FAIL misaligned_fetch_sticky got fault=%b code=%b req=%b exp 1 01 0", Fault, FaultCode, MemReq);
        end
        pulse_reset();
        total++;
        if ({Fault, FaultCode, InstCount} !== {1'b0, 2'b00, 32'd0}) begin
            bad++; $display("[TB] FAIL misaligned_fetch_clear got fault=%b code=%b count=%0d exp 0 00 0", Fault, FaultCode, InstCount);
        end
        PC = 32'h0;
    endtask

    task automatic test_conflict;
        int c0;
        mem[0] = 32'h00002820;
        DpMemRead = 1'b1; DpMemWrite = 1'b1; DpAddr = 32'h10;
        fetch_waits = 0;
        start_instr(c0);
        repeat (2) @(posedge Clock); #1;
        total++;
        if ({Fault, FaultCode, MemReq, MemWe, MemAddr, MemWData} !== {1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            bad++; $display("[TB] FAIL conflict_fault got fault=%b code=%b req=%b we=%b addr=%h exp 1 10 0 0 0", Fault, FaultCode, MemReq, MemWe, MemAddr);
        end
        Run = 1'b1;
        repeat (5) @(posedge Clock); #1;
        Run = 1'b0;
        total++;
        if ({Fault, FaultCode} !== {1'b1, 2'b10}) begin
            bad++; $display("[TB] FAIL conflict_sticky got fault=%b code=%b exp 1 10", Fault, FaultCode);
        end
        pulse_reset();
        total++;
        if ({Fault, FaultCode} !== 3'b000) begin
            bad++; $display("[TB] FAIL conflict_clear got fault=%b code=%b exp 0 00", Fault, FaultCode);
        end
        DpMemWrite = 1'b0;
    endtask

    task automatic test_misaligned_data;
        int c0;
        DpMemRead = 1'b1; DpAddr = 32'h11;
        start_instr(c0);
        repeat (2) @(posedge Clock); #1;
        total++;
        if ({Fault, FaultCode, MemReq} !== {1'b1, 2'b01, 1'b0}) begin
            bad++; $display("[TB] FAIL misaligned_data_fault got fault=%b code=%b req=%b exp 1 01 0", Fault, FaultCode, MemReq);
        end
        pulse_reset();
        DpMemRead = 1'b0; DpAddr = 32'h0;
    endtask

    task automatic test_timeout;
        int c0;
        ack_en = 1'b0;
        start_instr(c0);
`ifdef MEM_TIMEOUT_EN
        repeat (3) @(posedge Clock); #1;
        total++;
        if ({Fault, MemReq} !== 2'b01) begin
            bad++; $display("[TB] FAIL timeout_early got fault=%b req=%b exp 0 1", Fault, MemReq);
        end
        @(posedge Clock); #1;
        total++;
        if ({Fault, FaultCode, MemReq} !== {1'b1, 2'b11, 1'b0}) begin
            bad++; $display("[TB] FAIL timeout_fault got fault=%b code=%b req=%b exp 1 11 0", Fault, FaultCode, MemReq);
        end
`else
        repeat (1000) @(posedge Clock); #1;
        total++;
        if ({Busy, MemReq, Fault, FaultCode, MemAddr} !== {1'b1, 1'b1, 1'b0, 2'b00, 32'h0}) begin
            bad++; $display("[TB] FAIL no_timeout_wait got busy=%b req=%b fault=%b code=%b exp 1 1 0 00", Busy, MemReq, Fault, FaultCode);
        end
`endif
        pulse_reset();
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid_fetch;
        int c0, delta;
        mem[0] = 32'h8CB10000; mem[4] = 32'h0BADF00D;
        DpMemRead = 1'b1; DpAddr = 32'h10;
        fetch_waits = 0; data_waits = 0;
        start_instr(c0);
        wait_step(c0, 10, delta);
        @(posedge Clock); #1;
        total++;
        if ({Data, InstCount} !== {32'h0BADF00D, 32'd1}) begin
            bad++; $display("[TB] FAIL pre_reset_load got data=%h count=%0d exp 0badf00d 1", Data, InstCount);
        end
        DpMemRead = 1'b0;
        ack_en = 1'b0;
        Run = 1'b1;
        @(posedge Clock); #1;
        total++;
        if (MemReq !== 1'b1) begin
            bad++; $display("[TB] FAIL mid_fetch_req got=%b exp=1", MemReq);
        end
        Reset = 1'b1;
        @(posedge Clock); #1;
        total++;
        if ({Inst, Data, Step, MemReq, MemWe, MemAddr, MemWData, Busy, Fault, FaultCode, InstCount} !== '0) begin
            bad++; $display("[TB] FAIL mid_fetch_reset got Inst=%h Data=%h MemReq=%b Busy=%b InstCount=%0d exp all zero", Inst, Data, MemReq, Busy, InstCount);
        end
        Reset = 1'b0; Run = 1'b0;
        @(posedge Clock); #1;
        total++;
        if ({MemReq, Busy} !== 2'b00) begin
            bad++; $display("[TB] FAIL after_reset_idle got req=%b busy=%b exp 0 0", MemReq, Busy);
        end
        ack_en = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_load();
        test_store();
        test_run_drop();
        test_misaligned_fetch();
        test_conflict();
        test_misaligned_data();
        test_timeout();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
